// File: rtl/mux_scan_controller_pkg.sv
// Shared definitions for the mux scan controller: FSM state encoding and default sizing.
package mux_scan_controller_pkg;

   localparam int NUM_CH_DEF = 12;
   localparam int SEL_W_DEF  = 4;
   localparam int SETTLE_DEF = 2;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/mux_scan_controller_settle_timer.sv
// Settle timer: loads a count on each select change and flags when the mux output may be sampled.
module mux_scan_controller_settle_timer #(
   parameter int SETTLE = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic done
);

   localparam int CNT_W = $clog2(SETTLE + 1);
   // Loading SETTLE-1 makes a just-loaded timer spend exactly SETTLE cycles before done.
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= LOAD_VAL;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/mux_scan_controller.sv
// Steps the mux select over all channels, waits for settling, samples each enabled channel and
// publishes a parallel snapshot with a one-cycle valid pulse and change flag.
module mux_scan_controller
   import mux_scan_controller_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int SEL_W  = SEL_W_DEF,
   parameter int SETTLE = SETTLE_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              continuous,
   input  logic [NUM_CH-1:0] chan_mask,
   input  logic              mux_in,
   output logic [SEL_W-1:0]  sel,
   output logic              busy,
   output logic [NUM_CH-1:0] scan_data,
   output logic              scan_valid,
   output logic              changed
);

   localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);

   state_t            state;
   logic [NUM_CH-1:0] mask_q;
   logic [NUM_CH-1:0] work;
   logic              scan_req;
   logic              timer_load;
   logic              timer_en;
   logic              timer_done;
   logic              last_ch;

   assign scan_req = start | continuous;
   assign last_ch  = (sel == LAST_SEL);
   assign timer_en = (state == S_SETTLE);

   // Reload the timer on every transition that lands in SETTLE with a new channel selected.
   always_comb begin
      timer_load = 1'b0;
      case (state)
         S_IDLE:   timer_load = scan_req;
         S_SETTLE: timer_load = !mask_q[sel] && !last_ch;
         S_SAMPLE: timer_load = !last_ch;
         S_DONE:   timer_load = continuous;
         default:  timer_load = 1'b0;
      endcase
   end

   mux_scan_controller_settle_timer #(
      .SETTLE (SETTLE)
   ) u_settle_timer (
      .clk  (clk),
      .rst  (rst),
      .load (timer_load),
      .en   (timer_en),
      .done (timer_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         sel        <= '0;
         busy       <= 1'b0;
         scan_data  <= '0;
         scan_valid <= 1'b0;
         changed    <= 1'b0;
         mask_q     <= '0;
         work       <= '0;
      end else begin
         scan_valid <= 1'b0;
         changed    <= 1'b0;
         case (state)
            S_IDLE: begin
               sel  <= '0;
               busy <= 1'b0;
               if (scan_req) begin
                  mask_q <= chan_mask;
                  work   <= '0;
                  busy   <= 1'b1;
                  state  <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               // A masked channel skips settling and sampling entirely: one cycle, bit forced to 0.
               if (!mask_q[sel]) begin
                  work[sel] <= 1'b0;
                  if (last_ch) begin
                     state <= S_DONE;
                  end else begin
                     sel <= sel + 1'b1;
                  end
               end else if (timer_done) begin
                  state <= S_SAMPLE;
               end
            end
            S_SAMPLE: begin
               work[sel] <= mux_in;
               if (last_ch) begin
                  state <= S_DONE;
               end else begin
                  sel   <= sel + 1'b1;
                  state <= S_SETTLE;
               end
            end
            S_DONE: begin
               scan_data  <= work;
               scan_valid <= 1'b1;
               changed    <= (work != scan_data);
               sel        <= '0;
               if (continuous) begin
                  mask_q <= chan_mask;
                  work   <= '0;
                  state  <= S_SETTLE;
               end else begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux_scan_controller.sv
// Directed bench for mux_scan_controller with a schedule-based reference model and per-cycle compare.
module tb_mux_scan_controller;

   localparam int NUM_CH = 12;
   localparam int SEL_W  = 4;
   localparam int SETTLE = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              continuous = 1'b0;
   logic [NUM_CH-1:0] chan_mask = 12'hFFF;
   logic [NUM_CH-1:0] pattern = 12'hA5C;
   logic              mux_in;
   logic [SEL_W-1:0]  sel;
   logic              busy;
   logic [NUM_CH-1:0] scan_data;
   logic              scan_valid;
   logic              changed;

   int n_cmp = 0;
   int n_err = 0;

   // Mux model: output is the selected channel's bit of the pattern.
   assign mux_in = pattern[sel];

   mux_scan_controller #(
      .NUM_CH (NUM_CH),
      .SEL_W  (SEL_W),
      .SETTLE (SETTLE)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .continuous (continuous),
      .chan_mask  (chan_mask),
      .mux_in     (mux_in),
      .sel        (sel),
      .busy       (busy),
      .scan_data  (scan_data),
      .scan_valid (scan_valid),
      .changed    (changed)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a scan is a queue of expected select values, one per cycle,
   // with the final entry standing for the DONE cycle.
   logic [SEL_W-1:0]  exp_sel_q[$];
   logic [NUM_CH-1:0] exp_mask = '0;
   logic [NUM_CH-1:0] exp_data = '0;
   logic              exp_valid = 1'b0;
   logic              exp_changed = 1'b0;

   task automatic plan_scan();
      exp_mask = chan_mask;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         int n;
         n = exp_mask[ch] ? SETTLE + 1 : 1;
         for (int k = 0; k < n; k++) exp_sel_q.push_back(SEL_W'(ch));
      end
      exp_sel_q.push_back(SEL_W'(NUM_CH - 1));
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_sel_q.delete();
         exp_data    = '0;
         exp_valid   = 1'b0;
         exp_changed = 1'b0;
      end else begin
         exp_valid   = 1'b0;
         exp_changed = 1'b0;
         if (exp_sel_q.size() != 0) begin
            void'(exp_sel_q.pop_front());
            if (exp_sel_q.size() == 0) begin
               exp_valid   = 1'b1;
               exp_changed = ((pattern & exp_mask) != exp_data);
               exp_data    = pattern & exp_mask;
               if (continuous) plan_scan();
            end
         end else if (start || continuous) begin
            plan_scan();
         end
      end
   end

   // Compare process: every cycle, just after the active edge.
   always begin
      logic [SEL_W-1:0] e_sel;
      @(posedge clk);
      #1;
      e_sel = (exp_sel_q.size() != 0) ? exp_sel_q[0] : '0;
      check("cyc_sel", 32'(sel), 32'(e_sel));
      check("cyc_busy", 32'(busy), 32'(exp_sel_q.size() != 0));
      check("cyc_scan_valid", 32'(scan_valid), 32'(exp_valid));
      check("cyc_changed", 32'(changed), 32'(exp_changed));
      check("cyc_scan_data", 32'(scan_data), 32'(exp_data));
   end

   task automatic start_scan();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!scan_valid && lat < 200);
      check("valid_seen", 32'(scan_valid), 32'd1);
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int lat;
      int extra;
      step(2);
      check("rst_sel", 32'(sel), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_data", 32'(scan_data), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      step(2);

      // 1: full scan of 12'hA5C
      start_scan();
      check("t1_busy", 32'(busy), 32'd1);
      wait_valid(lat);
      check("t1_latency", 32'(lat), 32'd37);
      check("t1_data", 32'(scan_data), 32'hA5C);
      check("t1_changed", 32'(changed), 32'd1);
      step(1);
      check("t1_valid_pulse", 32'(scan_valid), 32'd0);
      check("t1_busy_after", 32'(busy), 32'd0);

      // 2: identical rescan
      step(2);
      start_scan();
      wait_valid(lat);
      check("t2_latency", 32'(lat), 32'd37);
      check("t2_data", 32'(scan_data), 32'hA5C);
      check("t2_changed", 32'(changed), 32'd0);
      check("t2_busy_done", 32'(busy), 32'd0);

      // 3: partial mask
      step(2);
      chan_mask = 12'h00F;
      pattern   = 12'hFFF;
      start_scan();
      chan_mask = 12'hFFF;
      wait_valid(lat);
      check("t3_latency", 32'(lat), 32'd21);
      check("t3_data", 32'(scan_data), 32'h00F);
      check("t3_changed", 32'(changed), 32'd1);

      // 4: continuous, two back-to-back scans
      step(2);
      pattern = 12'h001;
      @(negedge clk);
      continuous = 1'b1;
      @(posedge clk);
      #1;
      wait_valid(lat);
      check("t4_latency1", 32'(lat), 32'd37);
      check("t4_data1", 32'(scan_data), 32'h001);
      check("t4_changed1", 32'(changed), 32'd1);
      check("t4_no_gap", 32'(busy), 32'd1);
      pattern = 12'h800;
      step(10);
      continuous = 1'b0;
      wait_valid(lat);
      check("t4_latency2", 32'(lat + 10), 32'd37);
      check("t4_data2", 32'(scan_data), 32'h800);
      check("t4_changed2", 32'(changed), 32'd1);
      step(3);
      check("t4_idle_busy", 32'(busy), 32'd0);
      check("t4_idle_sel", 32'(sel), 32'd0);

      // 5: start while busy is ignored
      start_scan();
      step(9);
      start = 1'b1;
      step(1);
      start = 1'b0;
      wait_valid(lat);
      check("t5_latency", 32'(lat + 10), 32'd37);
      check("t5_data", 32'(scan_data), 32'h800);
      extra = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1;
         if (scan_valid) extra++;
      end
      check("t5_extra_valid", 32'(extra), 32'd0);
      check("t5_busy", 32'(busy), 32'd0);

      // 6: asynchronous reset mid-scan, then restart
      pattern = 12'hA5C;
      start_scan();
      step(19);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("t6_rst_sel", 32'(sel), 32'd0);
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_data", 32'(scan_data), 32'd0);
      check("t6_rst_valid", 32'(scan_valid), 32'd0);
      check("t6_rst_changed", 32'(changed), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      step(2);
      start_scan();
      wait_valid(lat);
      check("t6_latency", 32'(lat), 32'd37);
      check("t6_data", 32'(scan_data), 32'hA5C);
      check("t6_changed", 32'(changed), 32'd1);
      step(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      n_err++;
      $display("FAIL watchdog: actual timeout required completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
